regfile_scanner: RTL

Sequential read-side companion to the 64-bit, 32-entry register file (two read ports `select_a`/`select_b` → `out_a`/`out_b`, one write port). On `start` it sweeps every register two at a time through both read ports, buffers each pair, and streams the words out one per beat over a valid/ready interface with their register index. Used for end-of-test state dumps and for debug snapshots of architectural state without touching the write port.

---
 rtl/regfile_scanner.sv | 137 +++++++++++++
 1 files changed

// File: rtl/regfile_scanner.sv
// Purpose : sweeps a 2-read-port register file pair by pair and streams every
//           word out over valid/ready with its register index (state dumps).
// Latency : start edge -> READ next cycle -> first dump_valid the cycle after;
//           3 cycles per pair at full rate, DONE pulse after the last beat.
// Backpressure: dump_valid holds with stable data/index until dump_ready;
//           the FSM simply waits, so no words are lost or duplicated.
// Ports   : clock/reset (async, active-low); start; select_a/select_b to the
//           regfile, out_a/out_b back; dump_valid/dump_ready/dump_data/
//           dump_index stream; busy, done pulse, checksum.
// Optional: REGFILE_SCAN_CHECKSUM_EN enables the running XOR on checksum;
//           otherwise checksum is tied to zero.
module regfile_scanner #(
  parameter int DATA_WIDTH = 64,
  parameter int SEL_WIDTH  = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic [SEL_WIDTH-1:0]  select_a,
  output logic [SEL_WIDTH-1:0]  select_b,
  input  logic [DATA_WIDTH-1:0] out_a,
  input  logic [DATA_WIDTH-1:0] out_b,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic [SEL_WIDTH-1:0]  dump_index,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_READ   = 3'd1;
  localparam logic [2:0] ST_EMIT_A = 3'd2;
  localparam logic [2:0] ST_EMIT_B = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [SEL_WIDTH-2:0] LAST_P  = (SEL_WIDTH-1)'(NUM_REGS/2 - 1);
  localparam logic [SEL_WIDTH-2:0] P_ONE   = 1;
  localparam logic [SEL_WIDTH-1:0] SEL_ONE = 1;

  logic [2:0]            state;
  logic [SEL_WIDTH-2:0]  p;
  logic [SEL_WIDTH-2:0]  p_next;
  logic [DATA_WIDTH-1:0] hold_a;
  logic [DATA_WIDTH-1:0] hold_b;

  assign p_next = p + P_ONE;

  // The selects are registered so the regfile address is already stable for
  // the whole READ cycle; out_a/out_b are then captured at the end of READ,
  // which is what gives the per-pair snapshot semantics.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      p        <= '0;
      select_a <= '0;
      select_b <= '0;
      hold_a   <= '0;
      hold_b   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_READ;
            p        <= '0;
            select_a <= '0;
            select_b <= SEL_ONE;
          end
        end
        ST_READ: begin
          hold_a <= out_a;
          hold_b <= out_b;
          state  <= ST_EMIT_A;
        end
        ST_EMIT_A: begin
          if (dump_ready) state <= ST_EMIT_B;
        end
        ST_EMIT_B: begin
          if (dump_ready) begin
            if (p == LAST_P) begin
              state    <= ST_DONE;
              select_a <= '0;
              select_b <= '0;
            end else begin
              state    <= ST_READ;
              p        <= p_next;
              select_a <= {p_next, 1'b0};
              select_b <= {p_next, 1'b1};
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state so an async reset clears
  // them immediately rather than at the next edge.
  always_comb begin
    dump_valid = (state == ST_EMIT_A) || (state == ST_EMIT_B);
    dump_data  = '0;
    dump_index = '0;
    case (state)
      ST_EMIT_A: begin
        dump_data  = hold_a;
        dump_index = {p, 1'b0};
      end
      ST_EMIT_B: begin
        dump_data  = hold_b;
        dump_index = {p, 1'b1};
      end
      default: ;
    endcase
    busy = (state == ST_READ) || (state == ST_EMIT_A) || (state == ST_EMIT_B);
    done = (state == ST_DONE);
  end

`ifdef REGFILE_SCAN_CHECKSUM_EN
  // Cleared when a scan launches, so the final value survives DONE and IDLE
  // until the next start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      checksum <= '0;
    end else if ((state == ST_IDLE) && start) begin
      checksum <= '0;
    end else if (dump_valid && dump_ready) begin
      checksum <= checksum ^ dump_data;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule
